sig_waveform_gen: RTL

//  Programmable single-bit waveform transmitter: drives `signal` with N pulses of
//  H cycles high / L cycles low. It is the source end for the edge/change detectors.

---
 rtl/sig_gen_pkg.sv | 14 +
 rtl/phase_down_counter.sv | 28 ++
 rtl/sig_waveform_gen.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/sig_gen_pkg.sv
// Shared types and default widths for the single-bit waveform generator.
package sig_gen_pkg;

   localparam int SIG_GEN_CNT_W = 16;
   localparam int SIG_GEN_NUM_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2,
      FIN  = 2'd3
   } sig_gen_state_t;

endpackage

// File: rtl/phase_down_counter.sv
// Loadable down-counter that stops at zero; times one high or low phase.
module phase_down_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_load,
   input  logic         i_en,
   input  logic [W-1:0] i_value,
   output logic         o_zero
);

   logic [W-1:0] r_cnt;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_value;
      end else if (i_en && (r_cnt != '0)) begin
         r_cnt <= r_cnt - W'(1);
      end
   end

   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/sig_waveform_gen.sv
// Burst generator: N pulses of H cycles high / L cycles low, with registered
// edge-event, done and abort reporting.
module sig_waveform_gen
   import sig_gen_pkg::*;
#(
   parameter int CNT_W = SIG_GEN_CNT_W,
   parameter int NUM_W = SIG_GEN_NUM_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [CNT_W-1:0] high_len,
   input  logic [CNT_W-1:0] low_len,
   input  logic [NUM_W-1:0] num_pulses,
   output logic             signal,
   output logic             busy,
   output logic             done,
   output logic             aborted,
   output logic             rise_evt,
   output logic             fall_evt,
   output logic [NUM_W-1:0] pulse_count
);

   sig_gen_state_t   r_state, w_next;
   logic [CNT_W-1:0] r_high_len, r_low_len;
   logic [NUM_W-1:0] r_num, r_pulse_count;
   logic [CNT_W-1:0] w_high_clamp, w_low_clamp, w_cnt_value;
   logic             w_accept, w_abort_taken, w_high_end, w_cnt_load, w_cnt_en, w_cnt_zero;
   logic             w_signal, w_busy, w_done, w_rise, w_fall;
   logic             r_signal, r_busy, r_done, r_aborted, r_rise, r_fall;

   // A zero phase length would stall the down-counter, so it runs as one cycle.
   assign w_high_clamp = (high_len == '0) ? CNT_W'(1) : high_len;
   assign w_low_clamp  = (low_len  == '0) ? CNT_W'(1) : low_len;
   assign w_cnt_en     = (r_state == HIGH) || (r_state == LOW);

   phase_down_counter #(.W(CNT_W)) u_phase_cnt (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_cnt_load),
      .i_en    (w_cnt_en),
      .i_value (w_cnt_value),
      .o_zero  (w_cnt_zero)
   );

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      w_next        = r_state;
      w_accept      = 1'b0;
      w_abort_taken = 1'b0;
      w_high_end    = 1'b0;
      w_cnt_load    = 1'b0;
      w_cnt_value   = '0;
      case (r_state)
         IDLE: begin
            if (start && !abort) begin
               w_accept    = 1'b1;
               w_next      = (num_pulses == '0) ? FIN : HIGH;
               w_cnt_load  = 1'b1;
               w_cnt_value = w_high_clamp - CNT_W'(1);
            end
         end
         HIGH: begin
            if (abort) begin
               w_abort_taken = 1'b1;
               w_next        = IDLE;
            end else if (w_cnt_zero) begin
               w_high_end  = 1'b1;
               w_next      = LOW;
               w_cnt_load  = 1'b1;
               w_cnt_value = r_low_len - CNT_W'(1);
            end
         end
         LOW: begin
            if (abort) begin
               w_abort_taken = 1'b1;
               w_next        = IDLE;
            end else if (w_cnt_zero) begin
               if (r_pulse_count == r_num) begin
                  w_next = FIN;
               end else begin
                  w_next      = HIGH;
                  w_cnt_load  = 1'b1;
                  w_cnt_value = r_high_len - CNT_W'(1);
               end
            end
         end
         FIN:     w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Outputs are decoded from the next state and registered, so they align with r_state.
   always_comb begin
      w_signal = (w_next == HIGH);
      w_busy   = (w_next == HIGH) || (w_next == LOW);
      w_done   = (w_next == FIN);
      w_rise   = (w_next == HIGH) && (r_state != HIGH);
      w_fall   = (r_state == HIGH) && (w_next != HIGH);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_signal  <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_aborted <= 1'b0;
         r_rise    <= 1'b0;
         r_fall    <= 1'b0;
      end else begin
         r_signal  <= w_signal;
         r_busy    <= w_busy;
         r_done    <= w_done;
         r_aborted <= w_abort_taken;
         r_rise    <= w_rise;
         r_fall    <= w_fall;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_high_len    <= '0;
         r_low_len     <= '0;
         r_num         <= '0;
         r_pulse_count <= '0;
      end else if (w_accept) begin
         r_high_len    <= w_high_clamp;
         r_low_len     <= w_low_clamp;
         r_num         <= num_pulses;
         r_pulse_count <= '0;
      end else if (w_high_end) begin
         r_pulse_count <= r_pulse_count + NUM_W'(1);
      end
   end

   assign signal      = r_signal;
   assign busy        = r_busy;
   assign done        = r_done;
   assign aborted     = r_aborted;
   assign rise_evt    = r_rise;
   assign fall_evt    = r_fall;
   assign pulse_count = r_pulse_count;

endmodule
